// File: rtl/sdc_close_sequencer.sv
// Drives the SDC close path: watchdog square wave, AS_close_SDC pulse, and ready/relay-feedback supervision.
// The inputs have 2 cycles of synchroniser latency, the outputs are registered in step with the state, and the block has no backpressure.
module sdc_close_sequencer #(
  parameter int WD_HALF_PERIOD  = 2500,
  parameter int READY_TIMEOUT   = 50000,
  parameter int CLOSE_PULSE_LEN = 1000,
  parameter int FB_DEBOUNCE     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       AS_driving_mode,
  input  logic       Close_request,
  input  logic       Open_request,
  input  logic       Fault_clear,
  input  logic       SDC_is_Ready,
  input  logic       SDC_closed_fb,
  output logic       Watchdog,
  output logic       AS_close_SDC,
  output logic [2:0] SDC_state,
  output logic       SDC_fault,
  output logic [2:0] Fault_code
);
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam int WW = $clog2(WD_HALF_PERIOD + 1);
  localparam int DW = $clog2(FB_DEBOUNCE + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_READY = 3'd1,
    CLOSING    = 3'd2,
    CLOSED     = 3'd3,
    OPENING    = 3'd4,
    FAULT      = 3'd5
  } state_e;

  logic [5:0]    meta_q, meta_d, sync_q, sync_d;
  logic          mode_s, close_s, open_s, clr_s, ready_s, fb_s;
  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          fb_stable_q, fb_stable_d;
  logic          wd_q, wd_d, close_q, close_d, fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic          abort, tmo_hit, healthy;

  always_comb begin
    meta_d = {AS_driving_mode, Close_request, Open_request, Fault_clear, SDC_is_Ready, SDC_closed_fb};
    sync_d = meta_q;
  end

  assign {mode_s, close_s, open_s, clr_s, ready_s, fb_s} = sync_q;

  // Samples that differ from the accepted level are all equal to each other, so one run counter suffices
  always_comb begin
    fb_stable_d = fb_stable_q;
    db_cnt_d    = '0;
    if (fb_s != fb_stable_q) begin
      if (db_cnt_q == DW'(FB_DEBOUNCE - 1)) begin
        fb_stable_d = fb_s;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    abort   = open_s | ~mode_s;
    tmo_hit = (tmo_q == TW'(READY_TIMEOUT - 1));
    case (state_q)
      IDLE: begin
        if (close_s && mode_s && !open_s) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (abort) state_d = OPENING;
        else if (ready_s) state_d = CLOSING;
        else if (tmo_hit) begin
          state_d = FAULT;
          code_d  = 3'd1;
        end
      end
      CLOSING: begin
        if (abort) state_d = OPENING;
        else if (fb_stable_q) state_d = CLOSED;
        else if (tmo_hit) begin
          state_d = FAULT;
          code_d  = 3'd2;
        end
      end
      CLOSED: begin
        // A lost relay outranks a simultaneous open request
        if (!fb_stable_q) begin
          state_d = FAULT;
          code_d  = 3'd3;
        end else if (abort) state_d = OPENING;
      end
      OPENING: begin
        if (!fb_stable_q) state_d = IDLE;
        else if (tmo_hit) begin
          state_d = FAULT;
          code_d  = 3'd4;
        end
      end
      FAULT: begin
        if (clr_s && !fb_stable_q) begin
          state_d = IDLE;
          code_d  = 3'd0;
        end
      end
      default: begin
        state_d = FAULT;
        code_d  = 3'd0;
      end
    endcase
  end

  always_comb begin
    tmo_d = '0;
    if (state_d == state_q) tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
    healthy  = state_d inside {IDLE, WAIT_READY, CLOSING, CLOSED};
    wd_d     = 1'b0;
    wd_cnt_d = '0;
    if (healthy) begin
      if (wd_cnt_q == WW'(WD_HALF_PERIOD - 1)) begin
        wd_d = ~wd_q;
      end else begin
        wd_cnt_d = wd_cnt_q + WW'(1);
        wd_d     = wd_q;
      end
    end
    close_d = (state_d == CLOSING) && (tmo_d < TW'(CLOSE_PULSE_LEN));
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q      <= '0;
      sync_q      <= '0;
      state_q     <= IDLE;
      tmo_q       <= '0;
      wd_cnt_q    <= '0;
      db_cnt_q    <= '0;
      fb_stable_q <= 1'b0;
      wd_q        <= 1'b0;
      close_q     <= 1'b0;
      fault_q     <= 1'b0;
      code_q      <= 3'd0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      wd_cnt_q    <= wd_cnt_d;
      db_cnt_q    <= db_cnt_d;
      fb_stable_q <= fb_stable_d;
      wd_q        <= wd_d;
      close_q     <= close_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
    end
  end

  assign Watchdog     = wd_q;
  assign AS_close_SDC = close_q;
  assign SDC_state    = state_q;
  assign SDC_fault    = fault_q;
  assign Fault_code   = code_q;
endmodule

// File: tb/tb_sdc_close_sequencer.sv
// Scenario bench for sdc_close_sequencer: expected state transitions are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_sdc_close_sequencer;
  localparam int WD = 4, RT = 20, CPL = 8, FBD = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic mode = 1'b0, close_req = 1'b0, open_req = 1'b0, fclr = 1'b0, ready = 1'b0, fb = 1'b0;
  logic wd, as_close, fault;
  logic [2:0] st, code;
  int errors = 0, checks = 0;

  typedef struct packed {logic [2:0] st; logic [2:0] code; logic flt;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [2:0] last_st = 3'd0;

  always #5 clk = ~clk;

  sdc_close_sequencer #(
    .WD_HALF_PERIOD(WD), .READY_TIMEOUT(RT), .CLOSE_PULSE_LEN(CPL), .FB_DEBOUNCE(FBD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .AS_driving_mode(mode), .Close_request(close_req),
    .Open_request(open_req), .Fault_clear(fclr), .SDC_is_Ready(ready), .SDC_closed_fb(fb),
    .Watchdog(wd), .AS_close_SDC(as_close), .SDC_state(st), .SDC_fault(fault), .Fault_code(code)
  );

  // Every state change must match the next queued expectation
  always @(negedge clk) begin
    if (!rst_n) last_st = st;
    else if (st !== last_st) begin
      last_st = st;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL transition: unexpected state=%0d code=%0d fault=%0d", st, code, fault);
      end else begin
        mon_e = exp_q.pop_front();
        if ({st, code, fault} !== mon_e) begin
          errors++;
          $display("FAIL transition: got state=%0d code=%0d fault=%0d, expected state=%0d code=%0d fault=%0d",
                   st, code, fault, mon_e.st, mon_e.code, mon_e.flt);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input logic [2:0] s, input logic [2:0] c, input logic f);
    exp_q.push_back({s, c, f});
  endtask

  task automatic drain(input int bound, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cyc(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d transitions not seen within %0d cycles, state=%0d", name, exp_q.size(), bound, st);
      exp_q.delete();
    end
  endtask

  task automatic clear_fault(input string name);
    close_req = 1'b0; open_req = 1'b0; ready = 1'b0; fb = 1'b0;
    expect_st(3'd0, 3'd0, 1'b0);
    fclr = 1'b1;
    drain(30, name);
    fclr = 1'b0;
    checks++;
    if (code !== 3'd0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL %s: code=%0d fault=%0d after clear, expected 0 0", name, code, fault);
    end
  endtask

  task automatic goto_closed();
    expect_st(3'd1, 3'd0, 1'b0); expect_st(3'd2, 3'd0, 1'b0); expect_st(3'd3, 3'd0, 1'b0);
    mode = 1'b1; close_req = 1'b1; ready = 1'b1; fb = 1'b1;
    drain(40, "goto_closed");
  endtask

  task automatic test_reset();
    #12;
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL reset_wd: got %b expected 0", wd); end
    checks++; if (as_close !== 1'b0) begin errors++; $display("FAIL reset_close: got %b expected 0", as_close); end
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", st); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", code); end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_watchdog();
    int last_t = -1, n_tog = 0;
    bit bad = 0;
    logic prev;
    prev = wd;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (wd !== prev) begin
        if (last_t >= 0) begin
          checks++;
          if (i - last_t != WD) begin
            errors++;
            $display("FAIL idle_wd_period: toggle gap %0d cycles, expected %0d", i - last_t, WD);
          end
        end
        last_t = i; n_tog++; prev = wd;
      end
      if (as_close !== 1'b0 || st !== 3'd0) bad = 1;
    end
    checks++; if (n_tog < 9) begin errors++; $display("FAIL idle_wd_count: got %0d toggles expected >=9", n_tog); end
    checks++; if (bad) begin errors++; $display("FAIL idle_outputs: close/state left 0 during idle, expected 0"); end
  endtask

  task automatic test_close_seq();
    int hi = 0, wtog = 0;
    logic wdp;
    expect_st(3'd1, 3'd0, 1'b0); expect_st(3'd2, 3'd0, 1'b0); expect_st(3'd3, 3'd0, 1'b0);
    mode = 1'b1; close_req = 1'b1;
    cyc(5);
    ready = 1'b1;
    wdp = wd;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (as_close === 1'b1) hi++;
      if (wd !== wdp) begin wtog++; wdp = wd; end
    end
    fb = 1'b1;
    for (int i = 0; i < 30 && st !== 3'd3; i++) begin
      cyc(1);
      if (as_close === 1'b1) hi++;
      if (wd !== wdp) begin wtog++; wdp = wd; end
    end
    drain(10, "close_seq");
    checks++; if (hi == 0) begin errors++; $display("FAIL close_pulse: AS_close_SDC high %0d cycles, expected >0", hi); end
    checks++; if (as_close !== 1'b0) begin errors++; $display("FAIL closed_close: got %b expected 0", as_close); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL closed_fault: got %b expected 0", fault); end
    checks++; if (wtog < 2) begin errors++; $display("FAIL close_wd: %0d toggles, expected >=2", wtog); end
  endtask

  task automatic test_fb_glitch();
    fb = 1'b0; cyc(2); fb = 1'b1;
    cyc(10);
    checks++; if (st !== 3'd3) begin errors++; $display("FAIL fb_glitch_short: state %0d expected 3", st); end
    expect_st(3'd5, 3'd3, 1'b1);
    fb = 1'b0;
    drain(20, "fb_drop");
    cyc(1);
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL fb_drop_wd: got %b expected 0", wd); end
    checks++; if (code !== 3'd3) begin errors++; $display("FAIL fb_drop_code: got %0d expected 3", code); end
    clear_fault("fb_drop_clear");
  endtask

  task automatic test_ready_timeout();
    int n1 = 0;
    expect_st(3'd1, 3'd0, 1'b0); expect_st(3'd5, 3'd1, 1'b1);
    mode = 1'b1; close_req = 1'b1; ready = 1'b0; fb = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (st === 3'd1) n1++;
      if (st === 3'd5) break;
    end
    drain(5, "ready_timeout");
    checks++; if (n1 != RT) begin errors++; $display("FAIL ready_timeout_len: %0d cycles in WAIT_READY, expected %0d", n1, RT); end
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL ready_timeout_wd: got %b expected 0", wd); end
    checks++; if (code !== 3'd1) begin errors++; $display("FAIL ready_timeout_code: got %0d expected 1", code); end
    clear_fault("ready_timeout_clear");
  endtask

  task automatic test_close_timeout();
    int n2 = 0, nhi = 0;
    expect_st(3'd1, 3'd0, 1'b0); expect_st(3'd2, 3'd0, 1'b0); expect_st(3'd5, 3'd2, 1'b1);
    mode = 1'b1; close_req = 1'b1; ready = 1'b1; fb = 1'b0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (st === 3'd2) n2++;
      if (as_close === 1'b1) nhi++;
      if (st === 3'd5) break;
    end
    drain(5, "close_timeout");
    checks++; if (n2 != RT) begin errors++; $display("FAIL close_timeout_len: %0d cycles in CLOSING, expected %0d", n2, RT); end
    checks++; if (nhi != CPL) begin errors++; $display("FAIL close_pulse_len: AS_close_SDC high %0d cycles, expected %0d", nhi, CPL); end
    clear_fault("close_timeout_clear");
  endtask

  task automatic test_open_seq();
    int n4 = 0;
    bit wd_bad = 0;
    goto_closed();
    expect_st(3'd4, 3'd0, 1'b0);
    open_req = 1'b1;
    drain(10, "open_enter");
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      if (wd !== 1'b0) wd_bad = 1;
    end
    checks++; if (wd_bad) begin errors++; $display("FAIL opening_wd: Watchdog 1 in OPENING, expected 0"); end
    expect_st(3'd0, 3'd0, 1'b0);
    close_req = 1'b0; fb = 1'b0;
    drain(20, "open_to_idle");
    open_req = 1'b0;
    cyc(5);
    goto_closed();
    expect_st(3'd4, 3'd0, 1'b0); expect_st(3'd5, 3'd4, 1'b1);
    open_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (st === 3'd4) n4++;
      if (st === 3'd5) break;
    end
    drain(5, "open_timeout");
    checks++; if (n4 != RT) begin errors++; $display("FAIL open_timeout_len: %0d cycles in OPENING, expected %0d", n4, RT); end
    clear_fault("open_timeout_clear");
  endtask

  task automatic test_open_close_together();
    expect_st(3'd1, 3'd0, 1'b0);
    mode = 1'b1; close_req = 1'b1; ready = 1'b0; fb = 1'b0;
    drain(10, "both_wait");
    expect_st(3'd4, 3'd0, 1'b0); expect_st(3'd0, 3'd0, 1'b0);
    open_req = 1'b1;
    drain(10, "both_open");
    open_req = 1'b0; close_req = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset_mid_closing();
    expect_st(3'd1, 3'd0, 1'b0); expect_st(3'd2, 3'd0, 1'b0);
    mode = 1'b1; close_req = 1'b1; ready = 1'b1; fb = 1'b0;
    drain(10, "pre_reset");
    for (int i = 0; i < 5 && wd !== 1'b1; i++) cyc(1);
    checks++;
    if (as_close !== 1'b1 || wd !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_outputs: close=%b wd=%b, expected 1 1", as_close, wd);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (as_close !== 1'b0) begin errors++; $display("FAIL async_reset_close: got %b expected 0", as_close); end
    checks++; if (wd !== 1'b0) begin errors++; $display("FAIL async_reset_wd: got %b expected 0", wd); end
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL async_reset_state: got %0d expected 0", st); end
    mode = 1'b0; close_req = 1'b0; ready = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    checks++; if (st !== 3'd0) begin errors++; $display("FAIL post_reset_state: got %0d expected 0", st); end
  endtask

  initial begin
    test_reset();
    test_idle_watchdog();
    test_close_seq();
    test_fb_glitch();
    test_ready_timeout();
    test_close_timeout();
    test_open_seq();
    test_open_close_together();
    test_reset_mid_closing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end
endmodule
